lcd_text_writer: RTL and testbench

//  Console-style writer for the LCD character buffer: consumes a byte stream (valid/ready)

---
 rtl/lcd_text_writer.sv | 186 ++++++++++++++++++
 tb/tb_lcd_text_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// Console-style byte-stream writer for the LCD text RAM: cursor tracking, control codes, screen clear.
// Optional feature: define CLEAR_LINE_EN to blank each newly entered row (LINECLR state).
module lcd_text_writer #(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROWS     = 8,
  parameter logic [7:0]  CLR_CHAR = 8'h00
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wen,
  output logic [7:0]  wdata,
  output logic [15:0] waddr,
  output logic [7:0]  cur_row,
  output logic [7:0]  cur_col,
  output logic        busy
);

  localparam int unsigned CELLS    = COLS * ROWS;
  localparam logic [7:0]  LAST_COL = 8'(COLS - 1);
  localparam logic [7:0]  LAST_ROW = 8'(ROWS - 1);
  localparam logic [15:0] COLS16   = 16'(COLS);
  localparam logic [15:0] CELLS16  = 16'(CELLS);

  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_FF = 8'h0C;

`ifdef CLEAR_LINE_EN
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LINECLR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLEAR} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] waddr_q, waddr_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic [7:0]  next_row;
  logic [7:0]  bs_row, bs_col;

  function automatic logic [15:0] cell_addr(input logic [7:0] r, input logic [7:0] c);
    return 16'(r) * COLS16 + 16'(c);
  endfunction

  assign char_ready = ready_q;
  assign wen        = wen_q;
  assign wdata      = wdata_q;
  assign waddr      = waddr_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign busy       = busy_q;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      cnt_q   <= 16'd0;
      wen_q   <= 1'b0;
      wdata_q <= 8'd0;
      waddr_q <= 16'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Byte decode, cursor update and clear sequencing
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    wen_d    = 1'b0;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    accept   = char_valid && ready_q;
    next_row = (row_q == LAST_ROW) ? 8'd0 : row_q + 8'd1;
    bs_row   = row_q;
    bs_col   = col_q;

    if (col_q != 8'd0) begin
      bs_col = col_q - 8'd1;
    end else if (row_q != 8'd0) begin
      bs_row = row_q - 8'd1;
      bs_col = LAST_COL;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (char_data)
            C_LF: begin
              col_d = 8'd0;
              row_d = next_row;
`ifdef CLEAR_LINE_EN
              state_d = S_LINECLR;
              cnt_d   = 16'd0;
`endif
            end
            C_CR: col_d = 8'd0;
            C_BS: begin
              row_d   = bs_row;
              col_d   = bs_col;
              wen_d   = 1'b1;
              wdata_d = 8'h20;
              waddr_d = cell_addr(bs_row, bs_col);
            end
            C_FF: begin
              // First clear write goes out in the acceptance slot
              state_d = S_CLEAR;
              row_d   = 8'd0;
              col_d   = 8'd0;
              wen_d   = 1'b1;
              wdata_d = CLR_CHAR;
              waddr_d = 16'd0;
              cnt_d   = 16'd1;
            end
            default: begin
              wen_d   = 1'b1;
              wdata_d = char_data[7] ? 8'h3F : char_data;
              waddr_d = cell_addr(row_q, col_q);
              if (col_q == LAST_COL) begin
                col_d = 8'd0;
                row_d = next_row;
`ifdef CLEAR_LINE_EN
                state_d = S_LINECLR;
                cnt_d   = 16'd0;
`endif
              end else begin
                col_d = col_q + 8'd1;
              end
            end
          endcase
        end
      end
      S_CLEAR: begin
        if (cnt_q == CELLS16) begin
          state_d = S_IDLE;
        end else begin
          wen_d   = 1'b1;
          wdata_d = CLR_CHAR;
          waddr_d = cnt_q;
          cnt_d   = cnt_q + 16'd1;
        end
      end
`ifdef CLEAR_LINE_EN
      S_LINECLR: begin
        if (cnt_q == COLS16) begin
          state_d = S_IDLE;
        end else begin
          wen_d   = 1'b1;
          wdata_d = CLR_CHAR;
          waddr_d = 16'(row_q) * COLS16 + cnt_q;
          cnt_d   = cnt_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer: queue-based behavioural model plus directed literal checks.
module tb_lcd_text_writer;

  localparam int COLS = 64;
  localparam int ROWS = 8;

  logic        PixelClk = 1'b0;
  logic        nRST;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wen;
  logic [7:0]  wdata;
  logic [15:0] waddr;
  logic [7:0]  cur_row;
  logic [7:0]  cur_col;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 PixelClk = ~PixelClk;

  lcd_text_writer dut (
    .PixelClk  (PixelClk),
    .nRST      (nRST),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .wen       (wen),
    .wdata     (wdata),
    .waddr     (waddr),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy)
  );

  // One expected output cycle
  typedef struct {
    bit wen;
    int wdata;
    int waddr;
    int row;
    int col;
    bit ready;
    bit busy;
  } frame_t;

  frame_t q[$];
  frame_t cur;
  int     m_row;
  int     m_col;

  function automatic frame_t mk(bit w, int d, int a, int r, int c, bit rdy, bit bsy);
    frame_t f;
    f.wen = w; f.wdata = d; f.waddr = a; f.row = r; f.col = c; f.ready = rdy; f.busy = bsy;
    return f;
  endfunction

`ifdef CLEAR_LINE_EN
  function automatic void push_lineclr(int r);
    for (int i = 0; i < COLS; i++) q.push_back(mk(1'b1, 0, r * COLS + i, r, 0, 1'b0, 1'b1));
  endfunction
`endif

  // Expected output cycles produced by one accepted byte
  function automatic void model_accept(logic [7:0] b);
    int  code;
    int  a;
    bit  wrapped;
    case (b)
      8'h0A: begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
`ifdef CLEAR_LINE_EN
        q.push_back(mk(1'b0, 0, 0, m_row, 0, 1'b0, 1'b1));
        push_lineclr(m_row);
`else
        q.push_back(mk(1'b0, 0, 0, m_row, 0, 1'b1, 1'b0));
`endif
      end
      8'h0D: begin
        m_col = 0;
        q.push_back(mk(1'b0, 0, 0, m_row, 0, 1'b1, 1'b0));
      end
      8'h08: begin
        if (m_col > 0) m_col = m_col - 1;
        else if (m_row > 0) begin
          m_row = m_row - 1;
          m_col = COLS - 1;
        end
        q.push_back(mk(1'b1, 32, m_row * COLS + m_col, m_row, m_col, 1'b1, 1'b0));
      end
      8'h0C: begin
        m_row = 0;
        m_col = 0;
        for (int i = 0; i < COLS * ROWS; i++) q.push_back(mk(1'b1, 0, i, 0, 0, 1'b0, 1'b1));
      end
      default: begin
        code    = (b >= 8'h80) ? 63 : int'(b);
        a       = m_row * COLS + m_col;
        wrapped = (m_col == COLS - 1);
        if (wrapped) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
        end else begin
          m_col = m_col + 1;
        end
`ifdef CLEAR_LINE_EN
        if (wrapped) begin
          q.push_back(mk(1'b1, code, a, m_row, 0, 1'b0, 1'b1));
          push_lineclr(m_row);
        end else begin
          q.push_back(mk(1'b1, code, a, m_row, m_col, 1'b1, 1'b0));
        end
`else
        q.push_back(mk(1'b1, code, a, m_row, m_col, 1'b1, 1'b0));
`endif
      end
    endcase
  endfunction

  // Model: advances one expected frame per clock; accepts only when nothing is queued
  initial begin
    cur   = mk(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    m_row = 0;
    m_col = 0;
    forever begin
      @(posedge PixelClk or negedge nRST);
      if (!nRST) begin
        q.delete();
        m_row = 0;
        m_col = 0;
        cur   = mk(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
      end else begin
        if (q.size() == 0 && char_valid === 1'b1) model_accept(char_data);
        if (q.size() > 0) cur = q.pop_front();
        else              cur = mk(1'b0, 0, 0, m_row, m_col, 1'b1, 1'b0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge PixelClk);
      if (cmp_en) begin
        chk("m_wen",   32'(wen),        32'(cur.wen));
        chk("m_ready", 32'(char_ready), 32'(cur.ready));
        chk("m_busy",  32'(busy),       32'(cur.busy));
        chk("m_row",   32'(cur_row),    32'(cur.row));
        chk("m_col",   32'(cur_col),    32'(cur.col));
        if (cur.wen) begin
          chk("m_wdata", 32'(wdata), 32'(cur.wdata));
          chk("m_waddr", 32'(waddr), 32'(cur.waddr));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with char_valid dropped
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    char_valid = 1'b1;
    char_data  = b;
    while (char_ready !== 1'b1 && n < 2000) begin
      @(negedge PixelClk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%0h ready never rose within %0d cycles", b, n);
    end
    @(posedge PixelClk);
    @(negedge PixelClk);
    char_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int cnt);
    for (int i = 0; i < cnt; i++) send(b);
  endtask

  task automatic chk_cursor(input string nm, input int r, input int c);
    chk({nm, "_row"}, 32'(cur_row), 32'(r));
    chk({nm, "_col"}, 32'(cur_col), 32'(c));
  endtask

  task automatic chk_write(input string nm, input int d, input int a);
    chk({nm, "_wen"},   32'(wen),   32'd1);
    chk({nm, "_wdata"}, 32'(wdata), 32'(d));
    chk({nm, "_waddr"}, 32'(waddr), 32'(a));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nRST       = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    cmp_en     = 1'b1;
    repeat (2) @(negedge PixelClk);
    chk("rst_wen",   32'(wen),        32'd0);
    chk("rst_wdata", 32'(wdata),      32'd0);
    chk("rst_waddr", 32'(waddr),      32'd0);
    chk("rst_ready", 32'(char_ready), 32'd1);
    chk("rst_busy",  32'(busy),       32'd0);
    chk_cursor("rst", 0, 0);
    nRST = 1'b1;
    @(negedge PixelClk);

    // Back-to-back printable bytes
    send(8'h48);
    chk_write("hi_h", 8'h48, 0);
    send(8'h69);
    chk_write("hi_i", 8'h69, 1);
    chk_cursor("hi", 0, 2);

    // Column wrap and full-screen row wrap
    send_n(8'h61, 61);
    chk_cursor("to_063", 0, 63);
    send(8'h41);
    chk_write("wrap_a", 8'h41, 63);
    chk_cursor("wrap_a", 1, 0);
    send_n(8'h0A, 6);
    send_n(8'h62, 63);
    chk_cursor("to_763", 7, 63);
    send(8'h42);
    chk_write("wrap_b", 8'h42, 511);
    chk_cursor("wrap_b", 0, 0);

    // LF, CR, BS across a row boundary, unlisted control byte
    send_n(8'h0A, 2);
    send_n(8'h63, 5);
    chk_cursor("to_25", 2, 5);
    send(8'h0A);
    chk("lf_wen", 32'(wen), 32'd0);
    chk_cursor("lf", 3, 0);
    send_n(8'h64, 4);
    send(8'h0D);
    chk("cr_wen", 32'(wen), 32'd0);
    chk_cursor("cr", 3, 0);
    send(8'h08);
    chk_write("bs_row", 8'h20, 191);
    chk_cursor("bs_row", 2, 63);
    send(8'h01);
    chk_write("ctl01", 8'h01, 191);
    chk_cursor("ctl01", 3, 0);

    // Full-screen clear
    send(8'h0C);
    chk("ff_busy",  32'(busy),       32'd1);
    chk("ff_ready", 32'(char_ready), 32'd0);
    chk_write("ff_first", 0, 0);
    n = 1;
    while (n < 600) begin
      @(negedge PixelClk);
      if (wen !== 1'b1) break;
      n++;
    end
    chk("ff_len", 32'(n), 32'd512);
    chk("ff_done_ready", 32'(char_ready), 32'd1);
    chk("ff_done_busy",  32'(busy),       32'd0);
    send(8'h58);
    chk_write("after_ff_x", 8'h58, 0);
    chk_cursor("after_ff_x", 0, 1);
    send(8'h08);
    chk_write("bs_01", 8'h20, 0);
    chk_cursor("bs_01", 0, 0);
    send(8'h08);
    chk_write("bs_00", 8'h20, 0);
    chk_cursor("bs_00", 0, 0);

    // Reset in the middle of a clear
    send(8'h0C);
    n = 0;
    while (waddr !== 16'd200 && n < 600) begin
      @(negedge PixelClk);
      n++;
    end
    chk("midclr_reached", 32'(waddr), 32'd200);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_wen",   32'(wen),        32'd0);
    chk("midrst_busy",  32'(busy),       32'd0);
    chk("midrst_ready", 32'(char_ready), 32'd1);
    chk("midrst_waddr", 32'(waddr),      32'd0);
    @(negedge PixelClk);
    #1 nRST = 1'b1;
    @(negedge PixelClk);
    chk_cursor("midrst", 0, 0);
    chk("midrst_idle_wen", 32'(wen), 32'd0);
    send(8'hC5);
    chk_write("hi_bit", 8'h3F, 0);
    chk_cursor("hi_bit", 0, 1);

`ifdef CLEAR_LINE_EN
    // Line clear on LF into a new row
    @(negedge PixelClk);
    #1 nRST = 1'b0;
    @(negedge PixelClk);
    #1 nRST = 1'b1;
    @(negedge PixelClk);
    send(8'h0A);
    send_n(8'h65, 3);
    chk_cursor("to_13", 1, 3);
    send(8'h0A);
    chk("lc_ready", 32'(char_ready), 32'd0);
    chk_cursor("lc", 2, 0);
    n = 0;
    while (wen !== 1'b1 && n < 10) begin
      @(negedge PixelClk);
      n++;
    end
    chk_write("lc_first", 0, 128);
    n = 1;
    while (n < 100) begin
      @(negedge PixelClk);
      if (wen !== 1'b1) break;
      n++;
    end
    chk("lc_len", 32'(n), 32'd64);
    send(8'h5A);
    chk_write("lc_z", 8'h5A, 128);
`endif

    repeat (3) @(negedge PixelClk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
